// File: rtl/synth_pkg.sv
// Shared types and constants for the note synthesizer: envelope states,
// envelope full scale, sample width and the phase-increment multiplier formula.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int ENV_W    = 9;
    localparam int ENV_FULL = 256;
    localparam int SAMPLE_W = 16;
    localparam int FREQ_W   = 16;

    // round(2^(phase_w+16) / rate): with a 16-bit fractional shift, freq * K >> 16
    // gives the per-sample phase step for a frequency in integer Hz.
    function automatic longint unsigned inc_k_calc(input int phase_w, input int rate);
        return ((64'd1 << (phase_w + 16)) + 64'(rate / 2)) / 64'(rate);
    endfunction

endpackage

// File: rtl/note_synth_tri_osc.sv
// Phase accumulator and triangle mapping; advances by inc on each tick,
// clear forces the phase back to zero and wins over tick.
module tri_osc
    import synth_pkg::*;
#(
    parameter int PHASE_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       clear,
    input  logic [PHASE_W-1:0]         inc,
    output logic [PHASE_W-1:0]         phase,
    output logic signed [SAMPLE_W-1:0] tri_val
);

    localparam logic signed [SAMPLE_W:0] HALF_POS = 17'sd32767;
    localparam logic signed [SAMPLE_W:0] HALF_NEG = 17'sd32768;

    logic [SAMPLE_W-1:0]        t;
    logic signed [SAMPLE_W:0]   t_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (tick) begin
            phase <= phase + inc;
        end
    end

    // The 16 bits below the MSB give position within the half-cycle; the MSB
    // selects the rising or falling ramp.
    assign t     = phase[PHASE_W-2 -: SAMPLE_W];
    assign t_ext = $signed({1'b0, t});

    always_comb begin
        tri_val = '0;
        if (phase[PHASE_W-1]) begin
            tri_val = SAMPLE_W'(HALF_POS - t_ext);
        end else begin
            tri_val = SAMPLE_W'(t_ext - HALF_NEG);
        end
    end

endmodule

// File: rtl/note_synth.sv
// Note synthesizer top: frequency handshake, glide toward the target, envelope
// FSM and output scaling around a triangle oscillator.
module note_synth
    import synth_pkg::*;
#(
    parameter int              SAMPLE_RATE = 48000,
    parameter int              PHASE_W     = 24,
    parameter longint unsigned INC_K       = inc_k_calc(PHASE_W, SAMPLE_RATE),
    parameter int              GLIDE_STEP  = 1,
    parameter int              ENV_STEP    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_en,
    input  logic [FREQ_W-1:0]          freq_in,
    input  logic                       freq_valid,
    output logic                       freq_ready,
    input  logic                       gate,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic [FREQ_W-1:0]          cur_freq,
    output logic                       active,
    output state_t                     dbg_state,
    output logic [ENV_W-1:0]           dbg_env,
    output logic [PHASE_W-1:0]         dbg_phase,
    output logic [FREQ_W-1:0]          dbg_tgt_freq
);

    localparam logic [FREQ_W-1:0] GSTEP = FREQ_W'(GLIDE_STEP);
    localparam logic [ENV_W-1:0]  ESTEP = ENV_W'(ENV_STEP);
    localparam logic [ENV_W-1:0]  EFULL = ENV_W'(ENV_FULL);

    // Handshake: freq_valid/freq_ready transfer a word when both are high at a
    // rising clk edge; freq_ready is high exactly while the pending slot is empty.
    logic                   pend_valid;
    logic [FREQ_W-1:0]      pend_freq;
    logic [FREQ_W-1:0]      tgt_freq;
    logic                   xfer;

    state_t                 state;
    logic [ENV_W-1:0]       env;
    logic [ENV_W:0]         env_sum;
    logic [ENV_W-1:0]       env_up;
    logic [ENV_W-1:0]       env_dn;
    logic [FREQ_W-1:0]      gap;
    logic [PHASE_W-1:0]     inc;
    logic [PHASE_W-1:0]     phase;
    logic signed [SAMPLE_W-1:0] tri_val;
    logic signed [31:0]     amp;
    logic                   osc_tick;
    logic                   osc_clear;

    assign freq_ready = ~pend_valid;
    assign xfer       = freq_valid & freq_ready;
    assign active     = (state != IDLE);

    assign dbg_state    = state;
    assign dbg_env      = env;
    assign dbg_phase    = phase;
    assign dbg_tgt_freq = tgt_freq;

    // The product is deliberately limited to 40 bits before the shift.
    assign inc = PHASE_W'((40'(cur_freq) * 40'(INC_K)) >> 16);

    assign env_sum = {1'b0, env} + {1'b0, ESTEP};
    assign env_up  = (env_sum >= {1'b0, EFULL}) ? EFULL : env_sum[ENV_W-1:0];
    assign env_dn  = (env > ESTEP) ? (env - ESTEP) : '0;

    assign gap = (cur_freq < tgt_freq) ? (tgt_freq - cur_freq) : (cur_freq - tgt_freq);

    assign amp = $signed({{16{tri_val[SAMPLE_W-1]}}, tri_val}) * $signed({23'b0, env});

    assign osc_tick  = sample_en && (state != IDLE);
    assign osc_clear = sample_en && (state == RELEASE) && !gate && (env_dn == '0);

    tri_osc #(
        .PHASE_W (PHASE_W)
    ) u_osc (
        .clk     (clk),
        .rst     (rst),
        .tick    (osc_tick),
        .clear   (osc_clear),
        .inc     (inc),
        .phase   (phase),
        .tri_val (tri_val)
    );

    // A zero frequency still completes the transfer but never reaches tgt_freq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_freq  <= '0;
            tgt_freq   <= '0;
        end else begin
            if (sample_en && pend_valid) begin
                pend_valid <= 1'b0;
                if (pend_freq != '0) begin
                    tgt_freq <= pend_freq;
                end
            end
            if (xfer) begin
                pend_valid <= 1'b1;
                pend_freq  <= freq_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_freq <= '0;
        end else if (sample_en) begin
            if (GLIDE_STEP == 0 || gap <= GSTEP) begin
                cur_freq <= tgt_freq;
            end else if (cur_freq < tgt_freq) begin
                cur_freq <= cur_freq + GSTEP;
            end else begin
                cur_freq <= cur_freq - GSTEP;
            end
        end
    end

    // Envelope FSM; out_sample uses the pre-tick envelope and phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            env        <= '0;
            out_sample <= '0;
        end else if (sample_en) begin
            out_sample <= SAMPLE_W'(amp >>> 8);
            case (state)
                IDLE: begin
                    if (gate) state <= ATTACK;
                end
                ATTACK: begin
                    if (!gate) begin
                        state <= RELEASE;
                    end else begin
                        env <= env_up;
                        if (env_up == EFULL) state <= SUSTAIN;
                    end
                end
                SUSTAIN: begin
                    if (!gate) state <= RELEASE;
                end
                RELEASE: begin
                    if (gate) begin
                        state <= ATTACK;
                    end else begin
                        env <= env_dn;
                        if (env_dn == '0) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
